mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-outstanding memory port
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] CNT_LAST  = 4'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        w_any_req;
    logic        w_grant_data;

    // On contention the port that did not win last time gets the grant.
    assign w_any_req    = if_req | d_req;
    assign w_grant_data = d_req & (~if_req | (r_last_grant == OWN_FETCH));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ISSUE;
            S_ISSUE: w_next = r_wr ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == CNT_LAST) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_last_grant <= OWN_DATA;
            r_owner      <= OWN_FETCH;
            r_wr         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_data;
                        r_last_grant <= w_grant_data;
                        r_addr       <= w_grant_data ? d_addr : if_addr;
                        r_wr         <= w_grant_data & d_wr;
                        r_wdata      <= w_grant_data ? d_wdata : 32'd0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= 4'd0;
                    if (r_wr) r_d_rdata <= 32'd0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    // Last wait cycle: memory data is valid now.
                    if (r_cnt == CNT_LAST) begin
                        if (r_owner == OWN_DATA) r_d_rdata  <= mem_rdata;
                        else                     r_if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = (r_state == S_ISSUE);
        mem_wr    = (r_state == S_ISSUE) & r_wr;
        if_ack    = (r_state == S_RESP) & (r_owner == OWN_FETCH);
        d_ack     = (r_state == S_RESP) & (r_owner == OWN_DATA);
        busy      = (r_state != S_IDLE);
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if_rdata  = r_if_rdata;
        d_rdata   = r_d_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        if_ack, d_ack, mem_en, mem_wr, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        a1_if_ack, a1_d_ack, a1_mem_en, a1_mem_wr, a1_busy;
    logic [31:0] a1_if_rdata, a1_d_rdata, a1_mem_addr, a1_mem_wdata;
    logic        a15_if_ack, a15_d_ack, a15_mem_en, a15_mem_wr, a15_busy;
    logic [31:0] a15_if_rdata, a15_d_rdata, a15_mem_addr, a15_mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.MEM_LAT(2)) dut (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata), .d_req(d_req), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .if_ack(a1_if_ack), .if_rdata(a1_if_rdata), .d_req(d_req), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(a1_d_ack), .d_rdata(a1_d_rdata),
        .mem_en(a1_mem_en), .mem_wr(a1_mem_wr), .mem_addr(a1_mem_addr),
        .mem_wdata(a1_mem_wdata), .mem_rdata(mem_rdata), .busy(a1_busy)
    );

    mem_arbiter #(.MEM_LAT(15)) dut15 (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .if_ack(a15_if_ack), .if_rdata(a15_if_rdata), .d_req(d_req), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(a15_d_ack), .d_rdata(a15_d_rdata),
        .mem_en(a15_mem_en), .mem_wr(a15_mem_wr), .mem_addr(a15_mem_addr),
        .mem_wdata(a15_mem_wdata), .mem_rdata(mem_rdata), .busy(a15_busy)
    );

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if_req = 1'($urandom); if_addr = $urandom; d_req = 1'($urandom);
            d_wr = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
            mem_rdata = $urandom;
            @(negedge clock);
            n_tests++;
            if ({if_ack, d_ack, mem_en, mem_wr, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: ack=%b/%b en=%b wr=%b busy=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
                         i, if_ack, d_ack, mem_en, mem_wr, busy, mem_addr, mem_wdata, if_rdata, d_rdata);
            end
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_fetch_read();
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        n_tests++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_issue: en=%b wr=%b addr=%h, required en=1 wr=0 addr=00000010", mem_en, mem_wr, mem_addr);
        end
        @(negedge clock);
        n_tests++;
        if (mem_en !== 1'b0 || busy !== 1'b1 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait: en=%b busy=%b ack=%b, required en=0 busy=1 ack=0", mem_en, busy, if_ack);
        end
        @(negedge clock);
        mem_rdata = 32'h00A0_0093;
        @(negedge clock);
        n_tests++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h00A0_0093 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_resp: if_ack=%b d_ack=%b if_rdata=%h mem_addr=%h, required 1 0 00a00093 00000010",
                     if_ack, d_ack, if_rdata, mem_addr);
        end
        if_req = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clock);
        n_tests++;
        if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h00A0_0093) begin
            n_fail++;
            $display("FAIL fetch_idle: ack=%b busy=%b if_rdata=%h, required 0 0 00a00093", if_ack, busy, if_rdata);
        end
    endtask

    task automatic test_contention();
        logic        owner [3];
        int          ack_cyc [3];
        logic [31:0] en_addr [3];
        int          n_ack, n_en;
        n_ack = 0; n_en = 0;
        @(negedge clock);
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
        mem_rdata = 32'h1234_5678;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (if_ack && d_ack) begin
                n_tests++; n_fail++;
                $display("FAIL ack_overlap at cycle %0d: if_ack=1 d_ack=1, required at most one", k);
            end
            if (mem_en && n_en < 3) begin en_addr[n_en] = mem_addr; n_en++; end
            if ((if_ack || d_ack) && n_ack < 3) begin
                owner[n_ack] = d_ack; ack_cyc[n_ack] = k; n_ack++;
            end
        end
        n_tests++;
        if (n_ack !== 3 || owner[0] !== 1'b0 || owner[1] !== 1'b1 || owner[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_order: %0d acks seen, owners %b%b%b, required 3 acks fetch,data,fetch (010)",
                     n_ack, owner[0], owner[1], owner[2]);
        end
        n_tests++;
        if (n_ack !== 3 || ack_cyc[0] !== 4 || ack_cyc[1] !== 9 || ack_cyc[2] !== 14) begin
            n_fail++;
            $display("FAIL grant_timing: ack cycles %0d,%0d,%0d, required 4,9,14", ack_cyc[0], ack_cyc[1], ack_cyc[2]);
        end
        n_tests++;
        if (n_en !== 3 || en_addr[0] !== 32'h40 || en_addr[1] !== 32'h200 || en_addr[2] !== 32'h40) begin
            n_fail++;
            $display("FAIL grant_addr: %0d issues, addrs %h %h %h, required 00000040 00000200 00000040",
                     n_en, en_addr[0], en_addr[1], en_addr[2]);
        end
        n_tests++;
        if (d_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL data_read: d_rdata=%h, required 12345678", d_rdata);
        end
        do_reset();
        @(negedge clock);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 8 && !d_ack; k++) @(negedge clock);
        d_req = 1'b0;
    endtask

    task automatic test_data_write();
        @(negedge clock);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        n_tests++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_issue: en=%b wr=%b addr=%h wdata=%h, required 1 1 00000100 deadbeef",
                     mem_en, mem_wr, mem_addr, mem_wdata);
        end
        @(negedge clock);
        n_tests++;
        if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 32'h0 || mem_wr !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_resp: d_ack=%b if_ack=%b d_rdata=%h mem_wr=%b wdata=%h, required 1 0 00000000 0 deadbeef",
                     d_ack, if_ack, d_rdata, mem_wr, mem_wdata);
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        int acks;
        acks = 0;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clock);
        @(negedge clock);
        if (if_ack) acks++;
        reset = 1'b1;
        @(negedge clock);
        if (if_ack) acks++;
        n_tests++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b en=%b ack=%b, required 0 0 0", busy, mem_en, if_ack);
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL reissue_after_reset: en=%b addr=%h, required 1 00000080", mem_en, mem_addr);
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL no_ack_on_abort: %0d acks, required 0", acks);
        end
        for (int k = 0; k < 8 && !if_ack; k++) @(negedge clock);
        if_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_latency_range();
        int lat1, lat2, lat15;
        lat1 = 0; lat2 = 0; lat15 = 0;
        do_reset();
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'hCAFE_0001;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            if (a1_if_ack  && lat1  == 0) lat1  = k;
            if (if_ack     && lat2  == 0) lat2  = k;
            if (a15_if_ack && lat15 == 0) lat15 = k;
        end
        n_tests++;
        if (lat1 !== 3) begin
            n_fail++;
            $display("FAIL latency_1: ack at T+%0d, required T+3", lat1);
        end
        n_tests++;
        if (lat2 !== 4) begin
            n_fail++;
            $display("FAIL latency_2: ack at T+%0d, required T+4", lat2);
        end
        n_tests++;
        if (lat15 !== 17) begin
            n_fail++;
            $display("FAIL latency_15: ack at T+%0d, required T+17", lat15);
        end
        n_tests++;
        if (a1_if_rdata !== 32'hCAFE_0001 || a15_if_rdata !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL latency_rdata: %h / %h, required cafe0001", a1_if_rdata, a15_if_rdata);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_contention();
        test_data_write();
        test_reset_mid_wait();
        test_latency_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
